// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline register with stall detection and decode-stage beq/j resolution.
// Optional saturating performance counters are enabled by defining IFID_PERF_CNT_EN.
module if_id_hazard_ctrl #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] nextInstAdr,
    input  logic [INST_W-1:0] Inst,
    input  logic              regEq,
    input  logic              exMemRead,
    input  logic              exRegWrite,
    input  logic [4:0]        exWriteReg,
    input  logic              memMemRead,
    input  logic [4:0]        memWriteReg,
    output logic              pcWrite,
    output logic              flush,
    output logic              PcSrc,
    output logic              jmp,
    output logic [ADDR_W-1:0] beqAdr,
    output logic [25:0]       jmpAdr,
    output logic [INST_W-1:0] idInst,
    output logic [ADDR_W-1:0] idPc,
    output logic              idValid,
    output logic              bubble
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stallCnt,
    output logic [CNT_W-1:0]  flushCnt,
    output logic [CNT_W-1:0]  instCnt
`endif
);

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    logic [INST_W-1:0] r_idInst;
    logic [ADDR_W-1:0] r_idPc;
    logic              r_idValid;

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [15:0]       w_imm;
    logic [ADDR_W-1:0] w_immExt;
    logic              w_isBeq;
    logic              w_isJ;
    logic              w_loadUse;
    logic              w_brAlu;
    logic              w_brLoad;
    logic              w_stall;
    logic              w_taken;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic srcHit(input logic [4:0] dst, input logic [4:0] rs,
                                    input logic [4:0] rt);
        return (dst != 5'd0) && ((dst == rs) || (dst == rt));
    endfunction

    assign w_op     = r_idInst[31:26];
    assign w_rs     = r_idInst[25:21];
    assign w_rt     = r_idInst[20:16];
    assign w_imm    = r_idInst[15:0];
    assign w_immExt = {{(ADDR_W-16){w_imm[15]}}, w_imm};

    assign w_isBeq   = r_idValid && (w_op == OP_BEQ);
    assign w_isJ     = r_idValid && (w_op == OP_J);
    assign w_loadUse = exMemRead && srcHit(exWriteReg, w_rs, w_rt);
    assign w_brAlu   = w_isBeq && exRegWrite && srcHit(exWriteReg, w_rs, w_rt);
    assign w_brLoad  = w_isBeq && memMemRead && srcHit(memWriteReg, w_rs, w_rt);
    assign w_stall   = r_idValid && (w_loadUse || w_brAlu || w_brLoad);
    assign w_taken   = w_isBeq && regEq;

    // A stall suppresses any redirect: the branch is re-evaluated once operands are ready.
    assign pcWrite = !w_stall;
    assign bubble  = w_stall;
    assign PcSrc   = !w_stall && w_taken;
    assign jmp     = !w_stall && w_isJ;
    assign flush   = PcSrc || jmp;

    assign beqAdr  = r_idPc + (w_immExt << 2);
    assign jmpAdr  = r_idInst[25:0];
    assign idInst  = r_idInst;
    assign idPc    = r_idPc;
    assign idValid = r_idValid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idInst  <= '0;
            r_idPc    <= '0;
            r_idValid <= 1'b0;
        end else if (!w_stall) begin
            r_idInst  <= Inst;
            r_idPc    <= nextInstAdr;
            r_idValid <= !flush;
        end
    end

`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;
    logic [CNT_W-1:0] r_instCnt;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
            r_instCnt  <= '0;
        end else begin
            if (w_stall)
                r_stallCnt <= satInc(r_stallCnt);
            if (flush)
                r_flushCnt <= satInc(r_flushCnt);
            if (!w_stall && r_idValid)
                r_instCnt <= satInc(r_instCnt);
        end
    end

    assign stallCnt = r_stallCnt;
    assign flushCnt = r_flushCnt;
    assign instCnt  = r_instCnt;
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Bench for if_id_hazard_ctrl: directed vector table, hand sequences for reset
// and multi-cycle stalls, then randomized traffic against a behavioural model.
module tb_if_id_hazard_ctrl;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] nia;
        logic        regEq;
        logic        exMR;
        logic        exRW;
        logic [4:0]  exW;
        logic        memMR;
        logic [4:0]  memW;
    } ins_t;

    typedef struct packed {
        logic [31:0] idInst;
        logic [31:0] idPc;
        logic        idValid;
        logic        pcWrite;
        logic        flush;
        logic        PcSrc;
        logic        jmp;
        logic        bubble;
        logic [31:0] beqAdr;
        logic [25:0] jmpAdr;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t o;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] nextInstAdr;
    logic [31:0] Inst;
    logic        regEq;
    logic        exMemRead;
    logic        exRegWrite;
    logic [4:0]  exWriteReg;
    logic        memMemRead;
    logic [4:0]  memWriteReg;
    logic        pcWrite;
    logic        flush;
    logic        PcSrc;
    logic        jmp;
    logic [31:0] beqAdr;
    logic [25:0] jmpAdr;
    logic [31:0] idInst;
    logic [31:0] idPc;
    logic        idValid;
    logic        bubble;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;
    logic [15:0] instCnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    if_id_hazard_ctrl #(.ADDR_W(32), .INST_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .nextInstAdr(nextInstAdr), .Inst(Inst), .regEq(regEq),
        .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exWriteReg(exWriteReg),
        .memMemRead(memMemRead), .memWriteReg(memWriteReg), .pcWrite(pcWrite),
        .flush(flush), .PcSrc(PcSrc), .jmp(jmp), .beqAdr(beqAdr), .jmpAdr(jmpAdr),
        .idInst(idInst), .idPc(idPc), .idValid(idValid), .bubble(bubble)
`ifdef IFID_PERF_CNT_EN
        , .stallCnt(stallCnt), .flushCnt(flushCnt), .instCnt(instCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic ins_t mkin(input logic [31:0] inst, input logic [31:0] nia,
                                  input logic rq, input logic emr, input logic erw,
                                  input logic [4:0] ew, input logic mmr, input logic [4:0] mw);
        ins_t x;
        x.inst = inst; x.nia = nia; x.regEq = rq; x.exMR = emr; x.exRW = erw;
        x.exW = ew; x.memMR = mmr; x.memW = mw;
        return x;
    endfunction

    function automatic outs_t mkout(input logic [31:0] ii, input logic [31:0] ip, input logic iv,
                                    input logic pw, input logic fl, input logic ps, input logic jp,
                                    input logic bb, input logic [31:0] ba, input logic [25:0] ja);
        outs_t o;
        o.idInst = ii; o.idPc = ip; o.idValid = iv; o.pcWrite = pw; o.flush = fl;
        o.PcSrc = ps; o.jmp = jp; o.bubble = bb; o.beqAdr = ba; o.jmpAdr = ja;
        return o;
    endfunction

    // Behavioural reference: does a register named by the instruction match dst?
    function automatic bit reads_reg(input logic [31:0] inst, input logic [4:0] dst);
        int rs = int'(inst[25:21]);
        int rt = int'(inst[20:16]);
        int d  = int'(dst);
        return (d != 0) && (d == rs || d == rt);
    endfunction

    function automatic outs_t model(input logic [31:0] inst, input logic [31:0] pc,
                                    input logic valid, input ins_t x);
        outs_t o;
        int    op     = int'(inst[31:26]);
        bit    is_beq = valid && (op == 4);
        bit    is_j   = valid && (op == 2);
        bit    hold   = 0;
        int    offs   = int'($signed(inst[15:0])) * 4;
        if (valid) begin
            if (x.exMR && reads_reg(inst, x.exW))             hold = 1;
            if (is_beq && x.exRW && reads_reg(inst, x.exW))   hold = 1;
            if (is_beq && x.memMR && reads_reg(inst, x.memW)) hold = 1;
        end
        o.idInst  = inst;
        o.idPc    = pc;
        o.idValid = valid;
        o.pcWrite = !hold;
        o.bubble  = hold;
        o.PcSrc   = !hold && is_beq && x.regEq;
        o.jmp     = !hold && is_j;
        o.flush   = o.PcSrc || o.jmp;
        o.beqAdr  = pc + 32'(offs);
        o.jmpAdr  = inst[25:0];
        return o;
    endfunction

    function automatic outs_t sample();
        return mkout(idInst, idPc, idValid, pcWrite, flush, PcSrc, jmp, bubble, beqAdr, jmpAdr);
    endfunction

    task automatic apply(input ins_t x);
        Inst = x.inst; nextInstAdr = x.nia; regEq = x.regEq; exMemRead = x.exMR;
        exRegWrite = x.exRW; exWriteReg = x.exW; memMemRead = x.memMR; memWriteReg = x.memW;
    endtask

    task automatic chk_outs(input string name, input outs_t got, input outs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    vec_t        tbl[16];
    ins_t        x;
    outs_t       e;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic        m_valid;
    int          m_stall, m_flush, m_inst_cnt;

    initial begin
        tbl[0]  = '{mkin(32'h20080005, 32'h4,   0,0,0,0,0,0), mkout(32'h0,        32'h0,   0, 1,0,0,0,0, 32'h0,     26'h0)};
        tbl[1]  = '{mkin(32'h010A4820, 32'h8,   0,0,0,0,0,0), mkout(32'h20080005, 32'h4,   1, 1,0,0,0,0, 32'h18,    26'h0080005)};
        tbl[2]  = '{mkin(32'h1109FFFE, 32'h10,  0,1,0,8,0,0), mkout(32'h010A4820, 32'h8,   1, 0,0,0,0,1, 32'h12088, 26'h10A4820)};
        tbl[3]  = '{mkin(32'h1109FFFE, 32'h10,  0,0,0,8,0,0), mkout(32'h010A4820, 32'h8,   1, 1,0,0,0,0, 32'h12088, 26'h10A4820)};
        tbl[4]  = '{mkin(32'h0,        32'h14,  1,0,1,8,0,0), mkout(32'h1109FFFE, 32'h10,  1, 0,0,0,0,1, 32'h8,     26'h109FFFE)};
        tbl[5]  = '{mkin(32'h0,        32'h14,  1,0,0,0,0,0), mkout(32'h1109FFFE, 32'h10,  1, 1,1,1,0,0, 32'h8,     26'h109FFFE)};
        tbl[6]  = '{mkin(32'h08000040, 32'hC,   0,1,1,0,1,0), mkout(32'h0,        32'h14,  0, 1,0,0,0,0, 32'h14,    26'h0)};
        tbl[7]  = '{mkin(32'h0,        32'h10,  1,0,0,0,0,0), mkout(32'h08000040, 32'hC,   1, 1,1,0,1,0, 32'h10C,   26'h40)};
        tbl[8]  = '{mkin(32'h10220003, 32'h104, 0,0,0,0,0,0), mkout(32'h0,        32'h10,  0, 1,0,0,0,0, 32'h10,    26'h0)};
        tbl[9]  = '{mkin(32'h10000003, 32'h108, 0,0,0,0,0,0), mkout(32'h10220003, 32'h104, 1, 1,0,0,0,0, 32'h110,   26'h0220003)};
        tbl[10] = '{mkin(32'h20080005, 32'h10C, 0,1,1,0,1,0), mkout(32'h10000003, 32'h108, 1, 1,0,0,0,0, 32'h114,   26'h0000003)};
        tbl[11] = '{mkin(32'h1109FFFE, 32'h110, 0,0,0,0,0,0), mkout(32'h20080005, 32'h10C, 1, 1,0,0,0,0, 32'h120,   26'h0080005)};
        tbl[12] = '{mkin(32'h0,        32'h114, 0,1,0,9,0,0), mkout(32'h1109FFFE, 32'h110, 1, 0,0,0,0,1, 32'h108,   26'h109FFFE)};
        tbl[13] = '{mkin(32'h0,        32'h114, 0,0,0,0,1,9), mkout(32'h1109FFFE, 32'h110, 1, 0,0,0,0,1, 32'h108,   26'h109FFFE)};
        tbl[14] = '{mkin(32'h0,        32'h114, 0,0,0,0,0,0), mkout(32'h1109FFFE, 32'h110, 1, 1,0,0,0,0, 32'h108,   26'h109FFFE)};
        tbl[15] = '{mkin(32'h0,        32'h118, 0,0,0,0,1,0), mkout(32'h0,        32'h114, 1, 1,0,0,0,0, 32'h114,   26'h0)};

        rst = 1'b1;
        apply(mkin(32'h0, 32'h0, 0,0,0,0,0,0));
        #12;
        chk_outs("reset_state", sample(), mkout(32'h0, 32'h0, 0, 1,0,0,0,0, 32'h0, 26'h0));
`ifdef IFID_PERF_CNT_EN
        chk_val("reset_cnt", {stallCnt, flushCnt}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            apply(tbl[k].i);
            #2;
            chk_outs($sformatf("vec%0d", k), sample(), tbl[k].o);
            @(posedge clk);
            #1;
        end
`ifdef IFID_PERF_CNT_EN
        chk_val("tbl_stallCnt", {16'h0, stallCnt}, 32'd4);
        chk_val("tbl_flushCnt", {16'h0, flushCnt}, 32'd2);
        chk_val("tbl_instCnt",  {16'h0, instCnt},  32'd9);
`endif

        // Reset arriving while a branch is stalled clears the slot at once.
        apply(mkin(32'h1109FFFE, 32'h11C, 0,0,0,0,0,0));
        @(posedge clk);
        #1;
        x = mkin(32'h0, 32'h120, 1,0,1,8,0,0);
        apply(x);
        #1;
        chk_val("midstall_pcWrite", {31'h0, pcWrite}, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        chk_outs("rst_midstall", sample(), mkout(32'h0, 32'h0, 0, 1,0,0,0,0, 32'h0, 26'h0));
`ifdef IFID_PERF_CNT_EN
        chk_val("rst_midstall_cnt", {stallCnt, instCnt}, 32'h0);
        chk_val("rst_midstall_fcnt", {16'h0, flushCnt}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Load followed by a dependent beq: two stall cycles.
        apply(mkin(32'h1109FFFE, 32'h4, 0,0,0,0,0,0));
        @(posedge clk);
        #1;
        x = mkin(32'h0, 32'h8, 1,1,0,8,0,0);
        apply(x);
        #1;
        chk_outs("lwbeq_s1", sample(), mkout(32'h1109FFFE, 32'h4, 1, 0,0,0,0,1, 32'hFFFFFFFC, 26'h109FFFE));
        @(posedge clk);
        #1;
        x = mkin(32'h0, 32'h8, 1,0,0,0,1,8);
        apply(x);
        #1;
        chk_outs("lwbeq_s2", sample(), mkout(32'h1109FFFE, 32'h4, 1, 0,0,0,0,1, 32'hFFFFFFFC, 26'h109FFFE));
        @(posedge clk);
        #1;
        x = mkin(32'h0, 32'h8, 1,0,0,0,0,0);
        apply(x);
        #1;
        chk_outs("lwbeq_go", sample(), mkout(32'h1109FFFE, 32'h4, 1, 1,1,1,0,0, 32'hFFFFFFFC, 26'h109FFFE));
`ifdef IFID_PERF_CNT_EN
        chk_val("lwbeq_stallCnt", {16'h0, stallCnt}, 32'd2);
`endif
        @(posedge clk);
        #1;

        // Randomized traffic against the behavioural model.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_inst = '0; m_pc = '0; m_valid = 1'b0;
        m_stall = 0; m_flush = 0; m_inst_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ri;
            logic [5:0]  op;
            case ($urandom_range(0, 3))
                0:       op = 6'd4;
                1:       op = 6'd2;
                2:       op = 6'h23;
                default: op = 6'd0;
            endcase
            ri = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            x = mkin(ri, 32'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)));
            e = model(m_inst, m_pc, m_valid, x);
            if (e.flush)
                x.inst = 32'h0;
            apply(x);
            #2;
            chk_outs($sformatf("rand%0d", i), sample(), e);
`ifdef IFID_PERF_CNT_EN
            chk_val($sformatf("rand%0d_cnt", i), {stallCnt, flushCnt},
                    {16'(m_stall), 16'(m_flush)});
            chk_val($sformatf("rand%0d_icnt", i), {16'h0, instCnt}, 32'(m_inst_cnt));
`endif
            if (e.bubble)
                m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
            if (e.flush)
                m_flush = (m_flush < 65535) ? m_flush + 1 : m_flush;
            if (!e.bubble && m_valid)
                m_inst_cnt = (m_inst_cnt < 65535) ? m_inst_cnt + 1 : m_inst_cnt;
            if (!e.bubble) begin
                m_inst  = x.inst;
                m_pc    = x.nia;
                m_valid = !e.flush;
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
